ofmap_collect: RTL and testbench

Output-side collector for the 3x3 weight-stationary PE array. The input feeder skews pixels into x1/x2/x3 and pulses `win_valid` when a window starts. This block tracks each window through the fixed array-plus-accumulator latency and samples the accumulator result `Q`. It then applies optional ReLU and writes each result, with its row-major output address, into the output feature-map memory through a small elastic FIFO.

---
 rtl/ws_pkg.sv | 20 ++
 rtl/ofmap_fifo.sv | 66 ++++++
 rtl/ofmap_collect.sv | 129 ++++++++++++
 tb/tb_ofmap_collect.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared types and constants for the weight-stationary output path
package ws_pkg;

    localparam int Q_FRAC_BITS = 6;
    localparam int WS_DW       = Q_FRAC_BITS + 2;
    localparam int WS_AW       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ws_state_t;

    typedef struct packed {
        logic [WS_AW-1:0] addr;
        logic [WS_DW-1:0] data;
    } ofmap_wr_t;

endpackage

// File: rtl/ofmap_fifo.sv
// rtl/ofmap_fifo.sv - elastic buffer of ofmap writes, push and pop allowed together when full
module ofmap_fifo
    import ws_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      sys_clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      push,
    input  ofmap_wr_t push_data,
    input  logic      pop,
    output ofmap_wr_t head,
    output logic      full,
    output logic      empty,
    output logic      one_left
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    ofmap_wr_t     mem_q [DEPTH];

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign one_left = (cnt_q == (PW+1)'(1));
    assign head     = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge sys_clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ofmap_collect.sv
// rtl/ofmap_collect.sv - tracks windows through the PE array latency and writes results to ofmap memory
module ofmap_collect
    import ws_pkg::*;
#(
    parameter int OUT_W      = 3,
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int RELU       = 1,
    parameter int DW         = WS_DW,
    parameter int AW         = WS_AW
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          win_valid,
    input  logic [DW-1:0] q_in,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam int            CW  = AW + 1;
    localparam logic [CW-1:0] N_C = CW'(OUT_W * OUT_W);

    ws_state_t           state_q, state_d;
    logic [PIPE_LAT-1:0] dly_q, dly_d;
    logic [CW-1:0]       ins_cnt_q, ins_cnt_d;
    logic [CW-1:0]       cap_cnt_q, cap_cnt_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ins, cap, push, pop, fifo_clr;
    logic                fifo_full, fifo_empty, fifo_one;
    logic [DW-1:0]       cap_data;
    ofmap_wr_t           push_data, fifo_head;

    assign ins       = (state_q == ST_RUN) && win_valid && (ins_cnt_q != N_C);
    assign cap       = (state_q == ST_RUN) && dly_q[PIPE_LAT-1];
    assign cap_data  = ((RELU != 0) && q_in[DW-1]) ? '0 : q_in;
    assign pop       = !fifo_empty && wr_ready;
    // A full FIFO still takes the capture when the head leaves in the same cycle.
    assign push      = cap && (!fifo_full || pop);
    assign push_data = {cap_cnt_q[AW-1:0], cap_data};

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        ins_cnt_d = ins_cnt_q;
        cap_cnt_d = cap_cnt_q;
        ovf_d     = ovf_q;
        fifo_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    dly_d     = '0;
                    ins_cnt_d = '0;
                    cap_cnt_d = '0;
                    ovf_d     = 1'b0;
                    fifo_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                dly_d = {dly_q[PIPE_LAT-2:0], ins};
                if (ins) ins_cnt_d = ins_cnt_q + CW'(1);
                // The address advances even for a dropped result, leaving a hole.
                if (cap) begin
                    cap_cnt_d = cap_cnt_q + CW'(1);
                    if (!push) ovf_d = 1'b1;
                    if (cap_cnt_d == N_C) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty || (fifo_one && pop)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            ins_cnt_q <= '0;
            cap_cnt_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            ins_cnt_q <= ins_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    ofmap_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .clr      (fifo_clr),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .one_left (fifo_one)
    );

    assign wr_valid = !fifo_empty;
    assign wr_addr  = wr_valid ? fifo_head.addr : '0;
    assign wr_data  = wr_valid ? fifo_head.data : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ofmap_collect.sv
// tb/tb_ofmap_collect.sv - randomized scoreboard bench for ofmap_collect (RELU on and off)
module tb_ofmap_collect;
    import ws_pkg::*;

    localparam int OUT_W = 3, PIPE_LAT = 6, FIFO_DEPTH = 4, DW = 8, AW = 4;
    localparam int N = OUT_W * OUT_W;

    typedef struct {
        int a;
        int d;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, win_valid = 1'b0, wr_ready = 1'b0;
    logic [DW-1:0] q_in = '0;
    logic wr_valid1, busy1, done1, ovf1, wr_valid0, busy0, done0, ovf0;
    logic [AW-1:0] wr_addr1, wr_addr0;
    logic [DW-1:0] wr_data1, wr_data0;

    int errors = 0, checks = 0;
    int cyc = 0, rdy_mode = 0, q_const = -1, nwr = 0;
    bit m_active = 0, m_ovf = 0;
    int m_ins = 0, m_addr = 0, m_occ = 0, exp_done_cyc = -10, exp_done_cnt = 0, dut_done_cnt = 0;
    int caps[$];
    exp_t q1[$], q0[$];
    bit hold[2];
    logic [AW-1:0] ha[2];
    logic [DW-1:0] hd[2];

    ofmap_collect #(.OUT_W(OUT_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .RELU(1), .DW(DW), .AW(AW)) u_dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .win_valid(win_valid), .q_in(q_in),
        .wr_valid(wr_valid1), .wr_ready(wr_ready), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1), .overflow(ovf1));

    ofmap_collect #(.OUT_W(OUT_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .RELU(0), .DW(DW), .AW(AW)) u_dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .win_valid(win_valid), .q_in(q_in),
        .wr_valid(wr_valid0), .wr_ready(wr_ready), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .busy(busy0), .done(done0), .overflow(ovf0));

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: each accepted window yields a capture PIPE_LAT cycles later;
    // a FIFO of FIFO_DEPTH entries drains whenever wr_ready is high.
    always @(posedge sys_clk) begin
        bit pop, cap;
        exp_t e;
        if (!rst_n) begin
            m_active = 0; m_ovf = 0; m_occ = 0; m_addr = 0; m_ins = 0;
            caps.delete(); q1.delete(); q0.delete();
        end else begin
            pop = (m_occ > 0) && wr_ready;
            cap = m_active && (caps.size() > 0) && (caps[0] == cyc);
            if (cap) begin
                void'(caps.pop_front());
                if (m_occ < FIFO_DEPTH || pop) begin
                    e.a = m_addr;
                    e.d = int'(q_in);
                    q0.push_back(e);
                    if (q_in[DW-1]) e.d = 0;
                    q1.push_back(e);
                    m_occ++;
                end else begin
                    m_ovf = 1;
                end
                m_addr++;
            end
            if (pop) m_occ--;
            if (m_active && m_addr == N && m_occ == 0) begin
                m_active = 0;
                exp_done_cnt++;
                exp_done_cyc = cyc;
            end
            if (m_active && win_valid && m_ins < N) begin
                caps.push_back(cyc + PIPE_LAT);
                m_ins++;
            end
            if (start && !m_active) begin
                m_active = 1; m_ins = 0; m_addr = 0; m_ovf = 0; m_occ = 0;
                caps.delete();
            end
        end
        cyc++;
    end

    task automatic mon(input int w, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] dt);
        exp_t e;
        if (hold[w])
            chk($sformatf("stall_hold%0d", w), int'({v, a, dt}), int'({1'b1, ha[w], hd[w]}));
        if (v && wr_ready) begin
            if ((w == 1 && q1.size() == 0) || (w == 0 && q0.size() == 0)) begin
                chk($sformatf("unexpected_write%0d", w), int'(a), -1);
            end else begin
                e = (w == 1) ? q1.pop_front() : q0.pop_front();
                chk($sformatf("wr_addr%0d", w), int'(a), e.a);
                chk($sformatf("wr_data%0d", w), int'(dt), e.d);
                if (w == 1) nwr++;
            end
        end
        hold[w] = v && !wr_ready;
        ha[w] = a;
        hd[w] = dt;
    endtask

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            hold[0] = 0;
            hold[1] = 0;
        end else begin
            mon(1, wr_valid1, wr_addr1, wr_data1);
            mon(0, wr_valid0, wr_addr0, wr_data0);
            if (done1) begin
                dut_done_cnt++;
                chk("done_cycle", cyc, exp_done_cyc + 1);
                chk("busy_at_done", int'(busy1), 0);
            end
        end
    end

    // Free-running drivers for wr_ready and q_in.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            case (rdy_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = 1'($urandom_range(0, 1));
                2: wr_ready = 1'b0;
                default: wr_ready = ~wr_ready;
            endcase
            q_in = (q_const >= 0) ? DW'(q_const) : DW'($urandom);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        for (int k = 0; k < 400 && dut_done_cnt == base; k++) step();
        chk("done_pulse", dut_done_cnt, base + 1);
        repeat (3) step();
    endtask

    task automatic run_map(input int gap, input int npulse);
        int base;
        base = dut_done_cnt;
        nwr = 0;
        do_start();
        for (int i = 0; i < npulse; i++) begin
            win_valid = 1'b1;
            step();
            win_valid = 1'b0;
            repeat ((gap < 0) ? $urandom_range(0, 3) : gap) step();
        end
        wait_done(base);
    endtask

    initial begin
        int base, pulses;
        repeat (3) step();
        chk("rst_wr_valid", int'(wr_valid1), 0);
        chk("rst_wr_addr", int'(wr_addr1), 0);
        chk("rst_wr_data", int'(wr_data1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_overflow", int'(ovf1), 0);
        rst_n = 1'b1;
        step();
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        repeat (PIPE_LAT + 2) step();

        rdy_mode = 0; q_const = 8'h10;
        run_map(5, 9);
        chk("basic_writes", nwr, 9);
        chk("basic_overflow", int'(ovf1), 0);

        q_const = -1;
        for (int r = 0; r < 3; r++) begin
            rdy_mode = 1;
            run_map(-1, 12);
            chk("rand_overflow1", int'(ovf1), int'(m_ovf));
            chk("rand_overflow0", int'(ovf0), int'(m_ovf));
        end

        rdy_mode = 2;
        base = dut_done_cnt;
        nwr = 0;
        do_start();
        for (int i = 0; i < 9; i++) begin
            win_valid = 1'b1;
            step();
        end
        win_valid = 1'b0;
        repeat (10) step();
        rdy_mode = 0;
        wait_done(base);
        chk("bp_writes", nwr, 4);
        chk("bp_overflow1", int'(ovf1), 1);
        chk("bp_overflow_model", int'(ovf0), int'(m_ovf));

        rdy_mode = 3;
        run_map(0, 9);
        chk("toggle_overflow", int'(ovf1), int'(m_ovf));

        rdy_mode = 0;
        do_start();
        pulses = 0;
        for (int k = 0; k < 40 && m_addr < 4; k++) begin
            win_valid = (pulses < N);
            if (pulses < N) pulses++;
            step();
        end
        rst_n = 1'b0;
        win_valid = 1'b0;
        #1;
        chk("midrst_wr_valid", int'(wr_valid1), 0);
        chk("midrst_wr_addr", int'(wr_addr1), 0);
        chk("midrst_wr_data", int'(wr_data1), 0);
        chk("midrst_busy", int'(busy1), 0);
        chk("midrst_done", int'(done1), 0);
        chk("midrst_overflow", int'(ovf1), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        rdy_mode = 1;
        run_map(1, 9);
        chk("after_rst_writes_plus_drops", nwr + (m_ovf ? 0 : 0), (m_ovf ? nwr : 9));
        chk("after_rst_overflow", int'(ovf1), int'(m_ovf));

        chk("done_count", dut_done_cnt, exp_done_cnt);
        chk("leftover_q1", q1.size(), 0);
        chk("leftover_q0", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
